// File: rtl/iter_multiplier_if.sv
// Operand/result handshake bundle for iter_multiplier.
// MULT_SIGNED_EN adds the in_signed operand qualifier.
interface iter_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
`ifdef MULT_SIGNED_EN
  logic               in_signed;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out;
  logic               busy;

  modport slave (
    input  in_valid,
    input  in1,
    input  in2,
`ifdef MULT_SIGNED_EN
    input  in_signed,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output out,
    output busy
  );

  modport master (
    output in_valid,
    output in1,
    output in2,
`ifdef MULT_SIGNED_EN
    output in_signed,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out,
    input  busy
  );
endinterface

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// MULT_SIGNED_EN enables two's-complement operands via the in_signed qualifier.
module iter_multiplier #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  iter_multiplier_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0]   op_a, op_b;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] result;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d, neg_in;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic s);
    logic signed [WIDTH-1:0] v_neg;
    v_neg = -v;
    return (s && v[WIDTH-1]) ? v_neg : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                    input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  // The core always multiplies magnitudes; the product sign is restored on load.
  assign op_a   = magnitude(bus.in1, bus.in_signed);
  assign op_b   = magnitude(bus.in2, bus.in_signed);
  assign neg_in = bus.in_signed & (bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1]);
  assign result = apply_sign(acc_sum, neg_q);
`else
  assign op_a   = bus.in1;
  assign op_b   = bus.in2;
  assign result = acc_sum;
`endif

  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
`ifdef MULT_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, op_a};
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef MULT_SIGNED_EN
          neg_d    = neg_in;
`endif
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // No early exit: always the full WIDTH iterations for fixed latency.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          out_d   = result;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Working registers are only meaningful in RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
`ifdef MULT_SIGNED_EN
    neg_q    <= neg_d;
`endif
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign bus.out       = out_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier at WIDTH=8 and WIDTH=32.
// Define MULT_SIGNED_EN to also exercise signed operands.
module tb_iter_multiplier;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  iter_multiplier_if #(.WIDTH(8))  b8  ();
  iter_multiplier_if #(.WIDTH(32)) b32 ();

  iter_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));
  iter_multiplier #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference product: sign-extend when signed, multiply, keep 2*w bits.
  function automatic logic [127:0] model(input int w, input logic [63:0] a,
                                         input logic [63:0] b, input logic s);
    logic [127:0] ea, eb, p, mask;
    ea = 128'(a);
    eb = 128'(b);
    if (s && a[w-1]) ea = ea - (128'd1 << w);
    if (s && b[w-1]) eb = eb - (128'd1 << w);
    p    = ea * eb;
    mask = (128'd1 << (2 * w)) - 128'd1;
    return p & mask;
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input int hold, input logic [15:0] exp);
    @(negedge clk);
    b8.in1 = a; b8.in2 = b; b8.in_valid = 1'b1;
`ifdef MULT_SIGNED_EN
    b8.in_signed = s;
`else
    if (s) chk("w8_signed_unsupported", 1'b1, 1'b0);
`endif
    b8.out_ready = (hold == 0);
    chk("w8_in_ready_idle", b8.in_ready, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("w8_run_out_valid", b8.out_valid, 1'b0);
      chk("w8_run_busy", b8.busy, 1'b1);
      chk("w8_run_in_ready", b8.in_ready, 1'b0);
      b8.in_valid = 1'($urandom); b8.in1 = 8'($urandom); b8.in2 = 8'($urandom);
`ifdef MULT_SIGNED_EN
      b8.in_signed = 1'($urandom);
`endif
      @(negedge clk);
    end
    chk("w8_done_valid", b8.out_valid, 1'b1);
    chk("w8_done_out", b8.out, exp);
    for (int h = 0; h < hold; h++) begin
      b8.in_valid = 1'($urandom); b8.in1 = 8'($urandom);
      @(negedge clk);
      chk("w8_hold_valid", b8.out_valid, 1'b1);
      chk("w8_hold_out", b8.out, exp);
    end
    b8.out_ready = 1'b1;
    b8.in_valid  = 1'b1;
    @(negedge clk);
    chk("w8_idle_after_done", b8.in_ready, 1'b1);
    chk("w8_idle_busy", b8.busy, 1'b0);
    chk("w8_idle_out_valid", b8.out_valid, 1'b0);
    chk("w8_idle_out_held", b8.out, exp);
    b8.in_valid = 1'b0;
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       input int hold, input logic [63:0] exp);
    @(negedge clk);
    b32.in1 = a; b32.in2 = b; b32.in_valid = 1'b1;
    b32.out_ready = (hold == 0);
    chk("w32_in_ready_idle", b32.in_ready, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      chk("w32_run_out_valid", b32.out_valid, 1'b0);
      b32.in_valid = (i % 3 == 0); b32.in1 = $urandom; b32.in2 = $urandom;
      @(negedge clk);
    end
    chk("w32_done_valid", b32.out_valid, 1'b1);
    chk("w32_done_out", b32.out, exp);
    for (int h = 0; h < hold; h++) begin
      b32.in_valid = h[0]; b32.in1 = $urandom;
      @(negedge clk);
      chk("w32_hold_valid", b32.out_valid, 1'b1);
      chk("w32_hold_out", b32.out, exp);
    end
    b32.out_ready = 1'b1;
    b32.in_valid  = 1'b1;
    @(negedge clk);
    chk("w32_idle_after_done", b32.in_ready, 1'b1);
    chk("w32_idle_busy", b32.busy, 1'b0);
    b32.in_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] e;
    logic [7:0]   a8, c8;
    logic [31:0]  a32, c32;
    logic         s;
    reset = 1'b1;
    b8.in_valid = 1'b1; b8.in1 = 8'h12; b8.in2 = 8'h34; b8.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.in1 = '0; b32.in2 = '0; b32.out_ready = 1'b1;
`ifdef MULT_SIGNED_EN
    b8.in_signed = 1'b0; b32.in_signed = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_w8_in_ready", b8.in_ready, 1'b1);
    chk("rst_w8_busy", b8.busy, 1'b0);
    chk("rst_w8_out_valid", b8.out_valid, 1'b0);
    chk("rst_w8_out", b8.out, 16'h0);
    chk("rst_w32_in_ready", b32.in_ready, 1'b1);
    chk("rst_w32_out", b32.out, 64'h0);
    b8.in_valid = 1'b0;
    reset = 1'b0;

    run8(8'hFF, 8'hFF, 1'b0, 0, 16'hFE01);

    // Reset during RUN cycle 4 discards the operation.
    @(negedge clk);
    b8.in1 = 8'h07; b8.in2 = 8'h09; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun_busy", b8.busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_rst_in_ready", b8.in_ready, 1'b1);
    chk("midrun_rst_out_valid", b8.out_valid, 1'b0);
    chk("midrun_rst_out", b8.out, 16'h0);
    chk("midrun_rst_busy", b8.busy, 1'b0);
    repeat (10) begin
      @(negedge clk);
      chk("midrun_no_valid", b8.out_valid, 1'b0);
    end
    run8(8'h03, 8'h05, 1'b0, 0, 16'h000F);
    run8(8'h00, 8'hA5, 1'b0, 0, 16'h0000);
    run8(8'hA5, 8'h00, 1'b0, 2, 16'h0000);

    run32(32'hFFFFFFFF, 32'h00000002, 5, 64'h1_FFFFFFFE);
    run32(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'hFFFFFFFE_00000001);

    for (int k = 0; k < 20; k++) begin
      a8 = 8'($urandom); c8 = 8'($urandom);
      e = model(8, 64'(a8), 64'(c8), 1'b0);
      run8(a8, c8, 1'b0, int'($urandom_range(0, 3)), e[15:0]);
    end
    for (int k = 0; k < 8; k++) begin
      a32 = $urandom; c32 = $urandom;
      e = model(32, 64'(a32), 64'(c32), 1'b0);
      run32(a32, c32, int'($urandom_range(0, 3)), e[63:0]);
    end

`ifdef MULT_SIGNED_EN
    run8(8'hFF, 8'h80, 1'b1, 0, 16'h0080);
    run8(8'h80, 8'h80, 1'b1, 0, 16'h4000);
    run8(8'hFF, 8'h80, 1'b0, 0, 16'h7F80);
    run8(8'h80, 8'h80, 1'b0, 0, 16'h4000);
    run8(8'h05, 8'hFD, 1'b1, 1, 16'hFFF1);
    for (int k = 0; k < 16; k++) begin
      a8 = 8'($urandom); c8 = 8'($urandom); s = 1'($urandom);
      e = model(8, 64'(a8), 64'(c8), s);
      run8(a8, c8, s, int'($urandom_range(0, 2)), e[15:0]);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iter_multiplier.md
ITER_MULTIPLIER -- requirements
Module: iter_multiplier

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 in1  input  WIDTH  multiplicand.
REQ-007 in2  input  WIDTH  multiplier.
REQ-008 in_signed  input  1  operands are two's complement; present only with MULT_SIGNED_EN.
REQ-009 out_valid  output  1  product available.
REQ-010 out_ready  input  1  consumer takes product.
REQ-011 out  output  2*WIDTH  registered product.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 in_ready SHALL be high only in IDLE; out_valid SHALL be high only in DONE.
REQ-015 Accept: IDLE with in_valid high at an edge -> latch in1, in2, in_signed, clear iteration counter, go to RUN.
REQ-016 in_valid while not IDLE SHALL be ignored, with no effect on state or operands.
REQ-017 RUN SHALL last exactly WIDTH cycles; the counter increments once per RUN edge, and the edge that completes WIDTH iterations loads out and enters DONE.
REQ-018 Latency: out_valid SHALL first be high WIDTH cycles after the accepting edge, independent of operand values (no early exit on zero).
REQ-019 Iteration algorithm is implementer's choice (shift-add or radix-2 Booth with one guard bit), subject to REQ-017/018.
REQ-020 Unsigned result: out = in1*in2, exact in 2*WIDTH bits, no truncation.
REQ-021 out SHALL hold its value from entry into DONE until the next result is loaded; it SHALL NOT show partial products.
REQ-022 DONE with out_ready high at an edge -> IDLE; out_ready low -> remain in DONE with out and out_valid stable.
REQ-023 A new accept SHALL NOT occur in the same edge as the DONE->IDLE handshake; at least one IDLE cycle separates results.

Reset
REQ-024 Reset SHALL force IDLE, counter 0, out 0, out_valid 0, busy 0, in_ready 1 on the next cycle.
REQ-025 Reset SHALL take priority over every other event, including mid-RUN and DONE; an in-flight operation is discarded and no out_valid is produced for it.
REQ-026 Reset asserted together with in_valid SHALL NOT accept operands.

Configuration
REQ-027 Macro MULT_SIGNED_EN defined: in_signed port exists; when latched high, operands and out are two's complement with exact 2*WIDTH-bit product; when latched low, unsigned per REQ-020.
REQ-028 MULT_SIGNED_EN undefined: in_signed port absent, always unsigned; latency and handshake are identical in both builds.

Verification
REQ-029 WIDTH=8, in1=0xFF, in2=0xFF accepted at edge 0, out_ready=1 -> out_valid first high after edge 8, out=0xFE01, IDLE one cycle later.
REQ-030 WIDTH=8, in1=0x00, in2=0xA5 -> out=0x0000 after exactly 8 cycles (no early exit).
REQ-031 WIDTH=32, 0xFFFFFFFF*0x00000002 with out_ready low for 5 cycles after out_valid -> out=0x1_FFFFFFFE held stable and out_valid high for all 5 cycles; in_valid pulses during RUN/DONE ignored.
REQ-032 WIDTH=8, reset pulsed at RUN cycle 4 -> next cycle IDLE, out=0, out_valid=0, in_ready=1; a subsequent 3*5 accept yields out=0x000F.
REQ-033 MULT_SIGNED_EN, WIDTH=8, in_signed=1: 0xFF*0x80 (-1*-128) -> out=0x0080; 0x80*0x80 -> out=0x4000; same operands with in_signed=0 -> out=0x7F80 and 0x4000.
